// File: rtl/instr_de_queue.sv
// rtl/instr_de_queue.sv - RV32I decode stage: instr/PC FIFO feeding a registered decoded output slot
// Optional RV32M decode is enabled by defining DECODE_RV32M_EN.
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module instr_de_queue #(
  parameter int  DEPTH    = 4,
  parameter int  PC_WIDTH = 32,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        flush,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [31:0]                 in_instr,
  input  logic [PC_WIDTH-1:0]         in_pc,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PC_WIDTH-1:0]         out_pc,
  output logic [4:0]                  out_rs1,
  output logic [4:0]                  out_rs2,
  output logic [4:0]                  out_rd,
  output logic [31:0]                 out_imm,
  output logic [2:0]                  out_funct3,
  output logic [`ALU_WIDTH-1:0]       out_alu_op,
  output logic [`OPCODE_WIDTH-1:0]    out_opcode_type,
  output logic [`EXCEPTION_WIDTH-1:0] out_exception,
  output logic [7:0]                  out_m_op,
  output logic [LVL_W-1:0]            level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [LVL_W-1:0] FULL = LVL_W'(DEPTH);

  // One-hot bit positions of the decoded fields
  localparam int A_ADD = 0,  A_SUB = 1,  A_SLL = 2,  A_SLT = 3,  A_SLTU = 4,
                 A_XOR = 5,  A_SRL = 6,  A_SRA = 7,  A_OR  = 8,  A_AND  = 9,
                 A_EQ  = 10, A_NEQ = 11, A_GE  = 12, A_GEU = 13;
  localparam int T_RTYPE = 0, T_ITYPE = 1, T_LOAD = 2, T_STORE = 3, T_BRANCH = 4,
                 T_JAL = 5, T_JALR = 6, T_LUI = 7, T_AUIPC = 8, T_SYSTEM = 9, T_FENCE = 10;
  localparam int E_ILLEGAL = 0, E_ECALL = 1, E_EBREAK = 2, E_MRET = 3;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  logic [31:0]         instr_mem [DEPTH];
  logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0]    rd_ptr;
  logic [PTR_W-1:0]    wr_ptr;
  logic                push;
  logic                load;
  logic [31:0]         head_instr;
  logic [PC_WIDTH-1:0] head_pc;

  logic [6:0]                  opc;
  logic [2:0]                  f3;
  logic [6:0]                  f7;
  logic [31:0]                 imm_i;
  logic [31:0]                 imm_s;
  logic [31:0]                 imm_b;
  logic [31:0]                 imm_j;
  logic [31:0]                 imm_u;
  logic [31:0]                 imm_x;
  logic [`ALU_WIDTH-1:0]       dec_alu;
  logic [`OPCODE_WIDTH-1:0]    dec_type;
  logic [`EXCEPTION_WIDTH-1:0] dec_exc;
  logic [31:0]                 dec_imm;

  assign in_ready   = (level != FULL);
  assign push       = in_valid && in_ready;
  assign load       = (level != '0) && (!out_valid || out_ready);
  assign head_instr = instr_mem[rd_ptr];
  assign head_pc    = pc_mem[rd_ptr];

  assign opc   = head_instr[6:0];
  assign f3    = head_instr[14:12];
  assign f7    = head_instr[31:25];
  assign imm_i = {{20{head_instr[31]}}, head_instr[31:20]};
  assign imm_s = {{20{head_instr[31]}}, head_instr[31:25], head_instr[11:7]};
  assign imm_b = {{19{head_instr[31]}}, head_instr[31], head_instr[7],
                  head_instr[30:25], head_instr[11:8], 1'b0};
  assign imm_j = {{11{head_instr[31]}}, head_instr[31], head_instr[19:12],
                  head_instr[20], head_instr[30:21], 1'b0};
  assign imm_u = {head_instr[31:12], 12'd0};
  // SYSTEM carries its zero-extended CSR/function field as the X immediate
  assign imm_x = {20'd0, head_instr[31:20]};

  function automatic logic [`ALU_WIDTH-1:0] alu_arith(input logic [2:0] fn,
                                                      input logic alt,
                                                      input logic is_r);
    logic [`ALU_WIDTH-1:0] res;
    res = '0;
    case (fn)
      3'b000:  res[(is_r && alt) ? A_SUB : A_ADD] = 1'b1;
      3'b001:  res[A_SLL]  = 1'b1;
      3'b010:  res[A_SLT]  = 1'b1;
      3'b011:  res[A_SLTU] = 1'b1;
      3'b100:  res[A_XOR]  = 1'b1;
      3'b101:  res[alt ? A_SRA : A_SRL] = 1'b1;
      3'b110:  res[A_OR]   = 1'b1;
      default: res[A_AND]  = 1'b1;
    endcase
    return res;
  endfunction

  function automatic logic [`ALU_WIDTH-1:0] alu_branch(input logic [2:0] fn);
    logic [`ALU_WIDTH-1:0] res;
    res = '0;
    case (fn)
      3'b000:  res[A_EQ]   = 1'b1;
      3'b001:  res[A_NEQ]  = 1'b1;
      3'b100:  res[A_SLT]  = 1'b1;
      3'b101:  res[A_GE]   = 1'b1;
      3'b110:  res[A_SLTU] = 1'b1;
      3'b111:  res[A_GEU]  = 1'b1;
      default: res[A_ADD]  = 1'b1;
    endcase
    return res;
  endfunction

`ifdef DECODE_RV32M_EN
  logic [7:0] dec_m;
`endif

  always_comb begin
    dec_alu        = '0;
    dec_alu[A_ADD] = 1'b1;
    dec_type       = '0;
    dec_exc        = '0;
    dec_imm        = 32'd0;
`ifdef DECODE_RV32M_EN
    dec_m          = 8'd0;
`endif
    case (opc)
      OPC_OP: begin
        dec_type[T_RTYPE] = 1'b1;
        dec_alu           = alu_arith(f3, head_instr[30], 1'b1);
        if (f7 == 7'b0000001) begin
`ifdef DECODE_RV32M_EN
          dec_m[f3] = 1'b1;
          dec_alu   = '0;
`else
          dec_exc[E_ILLEGAL] = 1'b1;
`endif
        end else if ((f7 != 7'b0000000) && (f7 != 7'b0100000)) begin
          dec_exc[E_ILLEGAL] = 1'b1;
        end
      end
      OPC_IMM: begin
        dec_type[T_ITYPE]  = 1'b1;
        dec_alu            = alu_arith(f3, head_instr[30], 1'b0);
        dec_imm            = imm_i;
        dec_exc[E_ILLEGAL] = ((f3 == 3'b001) || (f3 == 3'b101)) && head_instr[25];
      end
      OPC_LOAD: begin
        dec_type[T_LOAD] = 1'b1;
        dec_imm          = imm_i;
      end
      OPC_STORE: begin
        dec_type[T_STORE] = 1'b1;
        dec_imm           = imm_s;
      end
      OPC_BRANCH: begin
        dec_type[T_BRANCH] = 1'b1;
        dec_alu            = alu_branch(f3);
        dec_imm            = imm_b;
      end
      OPC_JAL: begin
        dec_type[T_JAL] = 1'b1;
        dec_imm         = imm_j;
      end
      OPC_JALR: begin
        dec_type[T_JALR] = 1'b1;
        dec_imm          = imm_i;
      end
      OPC_LUI: begin
        dec_type[T_LUI] = 1'b1;
        dec_imm         = imm_u;
      end
      OPC_AUIPC: begin
        dec_type[T_AUIPC] = 1'b1;
        dec_imm           = imm_u;
      end
      OPC_SYSTEM: begin
        dec_type[T_SYSTEM] = 1'b1;
        dec_imm            = imm_x;
        if (f3 == 3'b000) begin
          case (head_instr[21:20])
            2'b00:   dec_exc[E_ECALL]  = 1'b1;
            2'b01:   dec_exc[E_EBREAK] = 1'b1;
            2'b10:   dec_exc[E_MRET]   = 1'b1;
            default: ;
          endcase
        end
      end
      OPC_FENCE: dec_type[T_FENCE] = 1'b1;
      default:   dec_exc[E_ILLEGAL] = 1'b1;
    endcase
  end

  // Storage is not reset; only pointers and level define what is valid
  always_ff @(posedge clk) begin
    if (!rst && !flush && push) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level           <= '0;
      rd_ptr          <= '0;
      wr_ptr          <= '0;
      out_valid       <= 1'b0;
      out_pc          <= '0;
      out_rs1         <= '0;
      out_rs2         <= '0;
      out_rd          <= '0;
      out_imm         <= '0;
      out_funct3      <= '0;
      out_alu_op      <= '0;
      out_opcode_type <= '0;
      out_exception   <= '0;
    end else if (flush) begin
      level     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (load) begin
        rd_ptr          <= rd_ptr + PTR_W'(1);
        out_valid       <= 1'b1;
        out_pc          <= head_pc;
        out_rs1         <= head_instr[19:15];
        out_rs2         <= head_instr[24:20];
        out_rd          <= head_instr[11:7];
        out_imm         <= dec_imm;
        out_funct3      <= f3;
        out_alu_op      <= dec_alu;
        out_opcode_type <= dec_type;
        out_exception   <= dec_exc;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case ({push, load})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: ;
      endcase
    end
  end

`ifdef DECODE_RV32M_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_m_op <= 8'd0;
    end else if (!flush && load) begin
      out_m_op <= dec_m;
    end
  end
`else
  assign out_m_op = 8'd0;
`endif

endmodule

// File: tb/tb_instr_de_queue.sv
// tb/tb_instr_de_queue.sv - self-checking bench for instr_de_queue against a queue-based reference model
`ifndef ALU_WIDTH
`define ALU_WIDTH 14
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 11
`endif
`ifndef EXCEPTION_WIDTH
`define EXCEPTION_WIDTH 4
`endif

module tb_instr_de_queue;
  localparam int DEPTH = 4;

  localparam int A_ADD = 0,  A_SUB = 1,  A_SLL = 2,  A_SLT = 3,  A_SLTU = 4,
                 A_XOR = 5,  A_SRL = 6,  A_SRA = 7,  A_OR  = 8,  A_AND  = 9,
                 A_EQ  = 10, A_NEQ = 11, A_GE  = 12, A_GEU = 13;
  localparam int X_ILL = 0, X_ECALL = 1, X_EBREAK = 2, X_MRET = 3;
  localparam int C_R = 0, C_I = 1, C_LOAD = 2, C_STORE = 3, C_BR = 4, C_JAL = 5,
                 C_JALR = 6, C_LUI = 7, C_AUIPC = 8, C_SYS = 9, C_FENCE = 10;

  // Opcode per class, indexed by its one-hot bit position
  localparam logic [6:0] OPC_TAB [11] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                          7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111,
                                          7'b0010111, 7'b1110011, 7'b0001111};
  localparam int RI_ALU [8] = '{A_ADD, A_SLL, A_SLT, A_SLTU, A_XOR, A_SRL, A_OR, A_AND};
  localparam int BR_ALU [8] = '{A_EQ, A_NEQ, A_ADD, A_ADD, A_SLT, A_GE, A_SLTU, A_GEU};

  typedef struct packed {
    logic [`ALU_WIDTH-1:0]       alu;
    logic [`OPCODE_WIDTH-1:0]    typ;
    logic [`EXCEPTION_WIDTH-1:0] exc;
    logic [31:0]                 imm;
    logic [7:0]                  m;
  } dec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  logic                        clk = 1'b0;
  logic                        rst;
  logic                        flush;
  logic                        in_valid;
  logic                        in_ready;
  logic [31:0]                 in_instr;
  logic [31:0]                 in_pc;
  logic                        out_valid;
  logic                        out_ready;
  logic [31:0]                 out_pc;
  logic [4:0]                  out_rs1;
  logic [4:0]                  out_rs2;
  logic [4:0]                  out_rd;
  logic [31:0]                 out_imm;
  logic [2:0]                  out_funct3;
  logic [`ALU_WIDTH-1:0]       out_alu_op;
  logic [`OPCODE_WIDTH-1:0]    out_opcode_type;
  logic [`EXCEPTION_WIDTH-1:0] out_exception;
  logic [7:0]                  out_m_op;
  logic [2:0]                  level;

  int tests = 0;
  int fails = 0;

  instr_de_queue #(.DEPTH(DEPTH), .PC_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_funct3(out_funct3), .out_alu_op(out_alu_op), .out_opcode_type(out_opcode_type),
    .out_exception(out_exception), .out_m_op(out_m_op), .level(level)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  function automatic dec_t ref_decode(input logic [31:0] ins);
    dec_t d;
    int cls, f3, f7;
    logic [31:0] sx;
    d   = '0;
    cls = -1;
    f3  = int'(ins[14:12]);
    f7  = int'(ins[31:25]);
    sx  = ins[31] ? 32'hFFFF_FFFF : 32'h0;
    for (int i = 0; i < 11; i++) if (ins[6:0] == OPC_TAB[i]) cls = i;
    d.alu[A_ADD] = 1'b1;
    if (cls < 0) begin
      d.exc[X_ILL] = 1'b1;
      return d;
    end
    d.typ[cls] = 1'b1;
    case (cls)
      C_R: begin
        d.alu = '0;
        if (f3 == 0)      d.alu[ins[30] ? A_SUB : A_ADD] = 1'b1;
        else if (f3 == 5) d.alu[ins[30] ? A_SRA : A_SRL] = 1'b1;
        else              d.alu[RI_ALU[f3]] = 1'b1;
        if (f7 == 1) begin
`ifdef DECODE_RV32M_EN
          d.alu  = '0;
          d.m[f3] = 1'b1;
`else
          d.exc[X_ILL] = 1'b1;
`endif
        end else if (f7 != 0 && f7 != 32) begin
          d.exc[X_ILL] = 1'b1;
        end
      end
      C_I: begin
        d.alu = '0;
        if (f3 == 5 && ins[30]) d.alu[A_SRA] = 1'b1;
        else                    d.alu[RI_ALU[f3]] = 1'b1;
        d.imm = (sx & 32'hFFFF_F000) | (ins >> 20);
        if ((f3 == 1 || f3 == 5) && ins[25]) d.exc[X_ILL] = 1'b1;
      end
      C_LOAD, C_JALR: d.imm = (sx & 32'hFFFF_F000) | (ins >> 20);
      C_STORE: d.imm = (sx & 32'hFFFF_F000) | ((ins >> 25) << 5) | ((ins >> 7) & 32'h1F);
      C_BR: begin
        d.alu = '0;
        d.alu[BR_ALU[f3]] = 1'b1;
        d.imm = (sx & 32'hFFFF_F000) | (((ins >> 7) & 32'h1) << 11)
              | (((ins >> 25) & 32'h3F) << 5) | (((ins >> 8) & 32'hF) << 1);
      end
      C_JAL: d.imm = (sx & 32'hFFF0_0000) | (ins & 32'h000F_F000)
                   | (((ins >> 20) & 32'h1) << 11) | (((ins >> 21) & 32'h3FF) << 1);
      C_LUI, C_AUIPC: d.imm = ins & 32'hFFFF_F000;
      C_SYS: begin
        d.imm = ins >> 20;
        if (f3 == 0) begin
          if (ins[21:20] == 2'd0)      d.exc[X_ECALL]  = 1'b1;
          else if (ins[21:20] == 2'd1) d.exc[X_EBREAK] = 1'b1;
          else if (ins[21:20] == 2'd2) d.exc[X_MRET]   = 1'b1;
        end
      end
      default: ;
    endcase
    return d;
  endfunction

  function automatic logic [31:0] gen_instr();
    logic [31:0] ins;
    int r;
    ins = $urandom;
    r = $urandom_range(99);
    if (r < 90) ins[6:0] = OPC_TAB[$urandom_range(10)];
    if (ins[6:0] == OPC_TAB[C_R]) begin
      r = $urandom_range(3);
      if (r == 0)      ins[31:25] = 7'b0000000;
      else if (r == 1) ins[31:25] = 7'b0100000;
      else if (r == 2) ins[31:25] = 7'b0000001;
    end
    if (ins[6:0] == OPC_TAB[C_SYS] && $urandom_range(1) == 1) ins[14:12] = 3'b000;
    return ins;
  endfunction

  task automatic push_one(input logic [31:0] ins, input logic [31:0] pc, output bit ok);
    bit acc;
    int n;
    acc = 1'b0;
    n = 0;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_instr  = ins;
    in_pc     = pc;
    while (!acc && n < 10) begin
      acc = in_ready;
      @(negedge clk);
      n++;
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    ok = acc && out_valid;
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic fill(input logic [31:0] base, output int accepted);
    bit acc;
    int n;
    accepted = 0;
    n = 0;
    out_ready = 1'b0;
    while (accepted < 5 && n < 20) begin
      in_valid = 1'b1;
      in_instr = 32'h0000_0013 | (32'(accepted) << 7);
      in_pc    = base + 32'(accepted) * 4;
      acc = in_ready;
      @(negedge clk);
      if (acc) accepted++;
      n++;
    end
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    in_instr = 32'h0050_0093; in_pc = 32'h40;
    @(negedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (level !== 3'd0) begin fails++; $display("FAIL reset_level got %0d want 0", level); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    tests++;
    if ({out_pc, out_imm, out_alu_op, out_opcode_type, out_exception, out_rd, out_m_op} !== '0) begin
      fails++;
      $display("FAIL reset_out_data got pc=%h imm=%h alu=%h typ=%h exc=%h rd=%0d m=%h want all 0",
               out_pc, out_imm, out_alu_op, out_opcode_type, out_exception, out_rd, out_m_op);
    end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h0050_0093; in_pc = 32'h100;
    @(negedge clk);
    in_valid = 1'b0;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_early_valid got %b want 0", out_valid); end
    tests++; if (level !== 3'd1) begin fails++; $display("FAIL addi_level got %0d want 1", level); end
    @(negedge clk);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL addi_latency got out_valid=%b want 1", out_valid); end
    tests++;
    if (out_opcode_type !== 11'h002 || out_alu_op !== 14'h0001 || out_rd !== 5'd1 ||
        out_imm !== 32'd5 || out_exception !== 4'h0 || out_pc !== 32'h100) begin
      fails++;
      $display("FAIL addi_decode got typ=%h alu=%h rd=%0d imm=%h exc=%h pc=%h want typ=002 alu=0001 rd=1 imm=5 exc=0 pc=100",
               out_opcode_type, out_alu_op, out_rd, out_imm, out_exception, out_pc);
    end
    consume();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL addi_drain got out_valid=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    int acc_n;
    fill(32'h200, acc_n);
    tests++; if (acc_n !== 5) begin fails++; $display("FAIL bp_accepted got %0d want 5", acc_n); end
    tests++; if (level !== 3'd4 || in_ready !== 1'b0) begin
      fails++; $display("FAIL bp_full got level=%0d in_ready=%b want 4/0", level, in_ready);
    end
    in_valid = 1'b1; in_instr = 32'h0000_0013; in_pc = 32'h2FC;
    for (int i = 0; i < 2; i++) begin
      tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_reject got in_ready=%b want 0", in_ready); end
      @(negedge clk);
    end
    in_valid = 1'b0;
    tests++; if (level !== 3'd4) begin fails++; $display("FAIL bp_level_hold got %0d want 4", level); end
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || out_pc !== 32'h200 + 32'(i) * 4) begin
        fails++; $display("FAIL bp_drain_%0d got valid=%b pc=%h want 1/%h", i, out_valid, out_pc, 32'h200 + 32'(i) * 4);
      end
      out_ready = 1'b1;
      @(negedge clk);
    end
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || level !== 3'd0) begin
      fails++; $display("FAIL bp_empty got valid=%b level=%0d want 0/0", out_valid, level);
    end
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int t = 0; t < 10; t++) begin
      in_valid = (t < 8);
      in_instr = 32'h0000_0013 | (32'(t) << 15);
      in_pc    = 32'h400 + 32'(t) * 4;
      @(negedge clk);
      tests++; if (level > 3'd1) begin fails++; $display("FAIL b2b_level t=%0d got %0d want <=1", t, level); end
      if (t >= 1 && t <= 8) begin
        tests++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400 + 32'(t - 1) * 4) begin
          fails++; $display("FAIL b2b_out t=%0d got valid=%b pc=%h want 1/%h", t, out_valid, out_pc, 32'h400 + 32'(t - 1) * 4);
        end
      end
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_end got valid=%b want 0", out_valid); end
    out_ready = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_flush();
    int acc_n;
    bit ok;
    fill(32'h600, acc_n);
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0070_0093; in_pc = 32'hDEAD0; out_ready = 1'b1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL flush_in_ready_pre got %b want 0", in_ready); end
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    tests++; if (level !== 3'd0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      fails++; $display("FAIL flush_state got level=%0d valid=%b in_ready=%b want 0/0/1", level, out_valid, in_ready);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL flush_ghost got valid=%b pc=%h want 0", out_valid, out_pc); end
    end
    out_ready = 1'b0;
    push_one(32'h0010_0093, 32'h800, ok);
    tests++; if (!ok || out_pc !== 32'h800 || out_rd !== 5'd1) begin
      fails++; $display("FAIL flush_recover got ok=%b pc=%h rd=%0d want 1/800/1", ok, out_pc, out_rd);
    end
    consume();
  endtask

  task automatic test_m_ext();
    bit ok;
    push_one(32'h0220_8033, 32'h900, ok);
    tests++; if (!ok) begin fails++; $display("FAIL mul_timeout got ok=0 want 1"); end
`ifdef DECODE_RV32M_EN
    tests++; if (out_m_op !== 8'h01 || out_exception !== 4'h0 || out_alu_op !== '0) begin
      fails++; $display("FAIL mul_decode got m=%h exc=%h alu=%h want 01/0/0", out_m_op, out_exception, out_alu_op);
    end
`else
    tests++; if (out_m_op !== 8'h00 || out_exception !== 4'h1) begin
      fails++; $display("FAIL mul_decode got m=%h exc=%h want 00/1", out_m_op, out_exception);
    end
`endif
    tests++; if (out_rd !== 5'd0 || out_rs1 !== 5'd1 || out_rs2 !== 5'd2) begin
      fails++; $display("FAIL mul_regs got rd=%0d rs1=%0d rs2=%0d want 0/1/2", out_rd, out_rs1, out_rs2);
    end
    consume();
  endtask

  task automatic test_system();
    logic [31:0] ins [4];
    logic [3:0]  exc [4];
    bit ok;
    ins[0] = 32'h0000_0073; exc[0] = 4'h2;
    ins[1] = 32'h0010_0073; exc[1] = 4'h4;
    ins[2] = 32'h3020_0073; exc[2] = 4'h8;
    ins[3] = 32'hFFFF_FFFF; exc[3] = 4'h1;
    for (int i = 0; i < 4; i++) begin
      push_one(ins[i], 32'hA00 + 32'(i) * 4, ok);
      tests++; if (!ok || out_exception !== exc[i]) begin
        fails++; $display("FAIL sys_%0d instr=%h got ok=%b exc=%h want 1/%h", i, ins[i], ok, out_exception, exc[i]);
      end
      consume();
    end
  endtask

  task automatic test_random();
    item_t q[$];
    item_t slot, it;
    bit    val, acc, ld;
    dec_t  d;
    logic [31:0] next_pc;
    q.delete();
    val = 1'b0;
    next_pc = 32'h1000;
    slot.instr = '0;
    slot.pc = '0;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 600; c++) begin
      tests++; if (level !== 3'(q.size())) begin fails++; $display("FAIL rnd_level c=%0d got %0d want %0d", c, level, q.size()); end
      tests++; if (out_valid !== val) begin fails++; $display("FAIL rnd_valid c=%0d got %b want %b", c, out_valid, val); end
      tests++; if (in_ready !== (q.size() != DEPTH)) begin fails++; $display("FAIL rnd_in_ready c=%0d got %b", c, in_ready); end
      if (val) begin
        d = ref_decode(slot.instr);
        tests++;
        if ({out_pc, out_rd, out_rs1, out_rs2, out_funct3, out_imm, out_alu_op, out_opcode_type, out_exception, out_m_op} !==
            {slot.pc, slot.instr[11:7], slot.instr[19:15], slot.instr[24:20], slot.instr[14:12], d.imm, d.alu, d.typ, d.exc, d.m}) begin
          fails++;
          $display("FAIL rnd_decode c=%0d instr=%h got pc=%h imm=%h alu=%h typ=%h exc=%h m=%h want pc=%h imm=%h alu=%h typ=%h exc=%h m=%h",
                   c, slot.instr, out_pc, out_imm, out_alu_op, out_opcode_type, out_exception, out_m_op,
                   slot.pc, d.imm, d.alu, d.typ, d.exc, d.m);
        end
      end
      rst       = (c == 300);
      flush     = ($urandom_range(99) < 2);
      in_valid  = ($urandom_range(99) < 70);
      in_instr  = gen_instr();
      in_pc     = next_pc;
      out_ready = ($urandom_range(99) < 60);
      if (rst || flush) begin
        q.delete();
        val = 1'b0;
      end else begin
        acc = in_valid && (q.size() != DEPTH);
        ld  = (q.size() != 0) && (!val || out_ready);
        if (ld) begin
          slot = q.pop_front();
          val  = 1'b1;
        end else if (val && out_ready) begin
          val = 1'b0;
        end
        if (acc) begin
          it.instr = in_instr;
          it.pc    = in_pc;
          q.push_back(it);
          next_pc = next_pc + 4;
        end
      end
      @(negedge clk);
    end
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instr = '0; in_pc = '0;
    test_reset();
    test_addi();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_m_ext();
    test_system();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
